// File: rtl/edge_detect_multi_if.sv
// rtl/edge_detect_multi_if.sv - pin-side bundle for the multi-channel edge detector
// evt_cnt only exists when EDGE_COUNT_EN is defined.
interface edge_detect_multi_if #(
  parameter int CH = 4
`ifdef EDGE_COUNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic [CH-1:0]      sig_in;
  logic [2*CH-1:0]    mode;
  logic [CH-1:0]      clr;
  logic [CH-1:0]      level;
  logic [CH-1:0]      edge_pulse;
  logic [CH-1:0]      evt_flag;
  logic               any_evt;
`ifdef EDGE_COUNT_EN
  logic [CNT_W*CH-1:0] evt_cnt;

  modport master (output sig_in, mode, clr,
                  input  level, edge_pulse, evt_flag, any_evt, evt_cnt);
  modport slave  (input  sig_in, mode, clr,
                  output level, edge_pulse, evt_flag, any_evt, evt_cnt);
`else
  modport master (output sig_in, mode, clr,
                  input  level, edge_pulse, evt_flag, any_evt);
  modport slave  (input  sig_in, mode, clr,
                  output level, edge_pulse, evt_flag, any_evt);
`endif
endinterface

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - per-channel sync, debounce, edge-mode pulse and sticky flag
// Optional saturating per-channel event counters when EDGE_COUNT_EN is defined.
module edge_detect_multi #(
  parameter int CH              = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
`ifdef EDGE_COUNT_EN
  , parameter int CNT_W         = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  edge_detect_multi_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [CH-1:0] w_level;
  logic [CH-1:0] w_pulse;
  logic [CH-1:0] w_flag;
`ifdef EDGE_COUNT_EN
  logic [CNT_W*CH-1:0] w_cnt;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_dcnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_flag;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync  <= '0;
        r_dcnt  <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
        r_flag  <= 1'b0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.sig_in[g]};
        r_pulse <= 1'b0;
        // flag follows the registered pulse, so a clear in the pulse cycle loses
        r_flag  <= r_pulse | (r_flag & ~bus.clr[g]);
        if (w_s == r_level) begin
          r_dcnt <= '0;
        end else if (r_dcnt != DCNT_LAST) begin
          r_dcnt <= r_dcnt + DW'(1);
        end else begin
          r_dcnt  <= '0;
          r_level <= w_s;
          r_pulse <= w_s ? bus.mode[2*g] : bus.mode[2*g+1];
        end
      end
    end

    assign w_level[g] = r_level;
    assign w_pulse[g] = r_pulse;
    assign w_flag[g]  = r_flag;

`ifdef EDGE_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (r_pulse) begin
        if (bus.clr[g])
          r_cnt <= CNT_W'(1);
        else if (!(&r_cnt))
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (bus.clr[g]) begin
        r_cnt <= '0;
      end
    end

    assign w_cnt[g*CNT_W +: CNT_W] = r_cnt;
`endif
  end

  assign bus.level      = w_level;
  assign bus.edge_pulse = w_pulse;
  assign bus.evt_flag   = w_flag;
  assign bus.any_evt    = |w_flag;
`ifdef EDGE_COUNT_EN
  assign bus.evt_cnt    = w_cnt;
`endif
endmodule
